g_core_arbiter: RTL and testbench

// - Two-requester round-robin arbiter and sequencer for one shared G permutation core (Gascon rounds + accumulate).
// - Captures a requester's capacity and round count, launches G, waits for G done, and returns cout/rout to that requester.
// - Sits between sponge absorb/squeeze controllers (requester 0/1) and the single G instance, so both share one core.

---
 rtl/g_core_arbiter.sv | 140 ++++++++++++++
 tb/tb_g_core_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/g_core_arbiter.sv
// Two-requester round-robin sequencer that shares one G permutation core.
// Optional RUN watchdog is enabled by defining G_ARB_TIMEOUT_EN.
module g_core_arbiter #(
  parameter int unsigned CWIDTH         = 320,
  parameter int unsigned RWIDTH         = 32,
  parameter int unsigned ROUND_COUNT    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [CWIDTH-1:0]      c0,
  input  logic [CWIDTH-1:0]      c1,
  input  logic [ROUND_COUNT-1:0] rounds0,
  input  logic [ROUND_COUNT-1:0] rounds1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   resp_valid,
  output logic                   resp_id,
  output logic                   resp_err,
  output logic [CWIDTH-1:0]      c_out,
  output logic [RWIDTH-1:0]      r_out,
  output logic                   busy,
  output logic [CWIDTH-1:0]      g_c,
  output logic [ROUND_COUNT-1:0] g_rounds,
  output logic                   g_reset,
  input  logic                   g_done,
  input  logic [CWIDTH-1:0]      g_cout,
  input  logic [RWIDTH-1:0]      g_rout
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StResp} state_e;

  state_e                 state;
  logic                   owner;
  logic                   last_owner;
  logic                   pick;
  logic [CWIDTH-1:0]      pick_c;
  logic [ROUND_COUNT-1:0] pick_rounds;

`ifdef G_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt;
`endif

  // On contention the requester that was not served last wins.
  always_comb begin
    pick        = (req0 && req1) ? ~last_owner : req1;
    pick_c      = pick ? c1 : c0;
    pick_rounds = pick ? rounds1 : rounds0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
      c_out      <= '0;
      r_out      <= '0;
      busy       <= 1'b0;
      g_c        <= '0;
      g_rounds   <= '0;
      g_reset    <= 1'b1;
`ifdef G_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            owner    <= pick;
            g_c      <= pick_c;
            g_rounds <= pick_rounds;
            grant0   <= ~pick;
            grant1   <= pick;
            busy     <= 1'b1;
            if (pick_rounds == '0) begin
              // Zero-round job is answered directly; G stays in reset.
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_id    <= pick;
              resp_err   <= 1'b1;
              c_out      <= pick_c;
              r_out      <= '0;
            end else begin
              state <= StLaunch;
            end
          end
        end
        StLaunch: begin
          state   <= StRun;
          g_reset <= 1'b0;
`ifdef G_ARB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        StRun: begin
          if (g_done) begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_err   <= 1'b0;
            c_out      <= g_cout;
            r_out      <= g_rout;
            g_reset    <= 1'b1;
          end
`ifdef G_ARB_TIMEOUT_EN
          else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            state      <= StResp;
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_err   <= 1'b1;
            c_out      <= '0;
            r_out      <= '0;
            g_reset    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        StResp: begin
          state      <= StIdle;
          last_owner <= owner;
          busy       <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_g_core_arbiter.sv
// Directed table-driven bench for g_core_arbiter plus multi-cycle sequences.
module tb_g_core_arbiter;

  localparam int unsigned CW = 320;
  localparam int unsigned RW = 32;
  localparam int unsigned NW = 10;

  localparam logic [CW-1:0] K0 = '0;
  localparam logic [CW-1:0] KG = 320'h5A5A;
  localparam logic [CW-1:0] KA = 320'hABCD;
  localparam logic [CW-1:0] KC = 320'h1234;
  localparam logic [RW-1:0] R0 = '0;
  localparam logic [RW-1:0] RG = 32'hC0DE;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [CW-1:0] c0, c1;
  logic [NW-1:0] rounds0, rounds1;
  logic          grant0, grant1, resp_valid, resp_id, resp_err, busy, g_reset, g_done;
  logic [CW-1:0] c_out, g_c, g_cout;
  logic [RW-1:0] r_out, g_rout;
  logic [NW-1:0] g_rounds;

  logic          tb_gd;
  logic          model_en;
  int unsigned   mcnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Simple G model: done on the third cycle after its reset is released.
  always @(posedge clk) begin
    if (g_reset) mcnt <= 0;
    else         mcnt <= mcnt + 1;
  end
  assign g_done = model_en ? (!g_reset && mcnt >= 2) : tb_gd;

  g_core_arbiter #(
    .CWIDTH        (CW),
    .RWIDTH        (RW),
    .ROUND_COUNT   (NW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .c0        (c0),
    .c1        (c1),
    .rounds0   (rounds0),
    .rounds1   (rounds1),
    .grant0    (grant0),
    .grant1    (grant1),
    .resp_valid(resp_valid),
    .resp_id   (resp_id),
    .resp_err  (resp_err),
    .c_out     (c_out),
    .r_out     (r_out),
    .busy      (busy),
    .g_c       (g_c),
    .g_rounds  (g_rounds),
    .g_reset   (g_reset),
    .g_done    (g_done),
    .g_cout    (g_cout),
    .g_rout    (g_rout)
  );

  typedef struct {
    logic          rst, r0, r1;
    logic [NW-1:0] n0, n1;
    logic          gd;
    logic          g0, g1, rv, rid, rerr, bsy, grst;
    logic [CW-1:0] cout;
    logic [RW-1:0] rout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic r0, logic r1, logic [NW-1:0] n0,
                              logic [NW-1:0] n1, logic gd, logic g0, logic g1, logic rv,
                              logic rid, logic rerr, logic bsy, logic grst,
                              logic [CW-1:0] cout, logic [RW-1:0] rout);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.n0 = n0; v.n1 = n1; v.gd = gd;
    v.g0 = g0; v.g1 = g1; v.rv = rv; v.rid = rid; v.rerr = rerr; v.bsy = bsy;
    v.grst = grst; v.cout = cout; v.rout = rout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    c0 = KC; c1 = KA; rounds0 = 10'd3; rounds1 = 10'd5;
    tb_gd = 1'b0; model_en = 1'b0; g_cout = KG; g_rout = RG;

    // rst r0 r1 n0 n1 gd | g0 g1 rv rid err bsy grst cout rout
    tbl.push_back(mk(0, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, K0, R0)); // reset
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, K0, R0));
    tbl.push_back(mk(1, 1, 0, 3, 5, 0, 1, 0, 0, 0, 0, 1, 1, K0, R0)); // single req0
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 1, 0, 0, 1, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0, 1, KG, RG)); // done in idle
    tbl.push_back(mk(0, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, K0, R0));
    tbl.push_back(mk(1, 1, 1, 3, 5, 0, 1, 0, 0, 0, 0, 1, 1, K0, R0)); // both -> 0
    tbl.push_back(mk(1, 0, 1, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, K0, R0));
    tbl.push_back(mk(1, 0, 1, 3, 5, 1, 0, 0, 1, 0, 0, 1, 1, KG, RG));
    tbl.push_back(mk(1, 0, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, KG, RG));
    tbl.push_back(mk(1, 0, 1, 3, 5, 0, 0, 1, 0, 0, 0, 1, 1, KG, RG)); // pending req1
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 1, 1, 0, 1, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 1, 0, 0, 1, KG, RG));
    tbl.push_back(mk(1, 0, 1, 3, 0, 0, 0, 1, 1, 1, 1, 1, 1, KA, R0)); // rounds1 == 0
    tbl.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0, 1, KA, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 0, 1, 1, 0, 1, KA, R0));
    tbl.push_back(mk(1, 1, 0, 3, 5, 0, 1, 0, 0, 1, 1, 1, 1, KA, R0));
    tbl.push_back(mk(1, 0, 1, 3, 5, 0, 0, 0, 0, 1, 1, 1, 0, KA, R0)); // req1 while busy
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 1, 0, 0, 1, 1, KG, RG)); // ...then dropped
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, KG, RG));
    tbl.push_back(mk(1, 0, 1, 3, 5, 0, 0, 1, 0, 0, 0, 1, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, KG, RG));
    tbl.push_back(mk(0, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, K0, R0)); // reset in RUN
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0, 1, K0, R0));
    tbl.push_back(mk(1, 1, 0, 3, 5, 0, 1, 0, 0, 0, 0, 1, 1, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 1, 0, K0, R0));
    tbl.push_back(mk(1, 0, 0, 3, 5, 1, 0, 0, 1, 0, 0, 1, 1, KG, RG));
    tbl.push_back(mk(1, 0, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1, KG, RG));

    #2;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      rounds0 = tbl[i].n0; rounds1 = tbl[i].n1; tb_gd = tbl[i].gd;
      tick();
      chk($sformatf("vec%0d", i),
          512'({grant0, grant1, resp_valid, resp_id, resp_err, busy, g_reset, c_out, r_out}),
          512'({tbl[i].g0, tbl[i].g1, tbl[i].rv, tbl[i].rid, tbl[i].rerr, tbl[i].bsy,
                tbl[i].grst, tbl[i].cout, tbl[i].rout}));
    end
    chk("g_c_captured", 512'(g_c), 512'(KC));
    chk("g_rounds_captured", 512'(g_rounds), 512'(10'd3));

    // Both requesters held continuously for six jobs: owners must alternate.
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; rounds0 = 10'd3; rounds1 = 10'd5; tb_gd = 1'b0;
    tick();
    reset = 1'b1; model_en = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 6; j++) begin
      bit got;
      g_cout = CW'(j + 17);
      g_rout = RW'(j + 40);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick();
        if (resp_valid) got = 1'b1;
      end
      chk($sformatf("job%0d_seen", j), 512'(got), 512'(1'b1));
      if (got) begin
        chk($sformatf("job%0d_result", j), 512'({resp_id, resp_err, c_out, r_out}),
            512'({1'(j % 2), 1'b0, CW'(j + 17), RW'(j + 40)}));
        tick();
        chk($sformatf("job%0d_single_pulse", j), 512'(resp_valid), 512'(1'b0));
      end
    end
    req0 = 1'b0; req1 = 1'b0; model_en = 1'b0;

`ifdef G_ARB_TIMEOUT_EN
    // G never finishes: watchdog aborts after 16 RUN cycles.
    begin
      bit got;
      int runs;
      reset = 1'b0; tb_gd = 1'b0; g_cout = KG; g_rout = RG;
      tick();
      reset = 1'b1; req0 = 1'b1;
      tick();
      req0 = 1'b0;
      got = 1'b0; runs = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick();
        if (resp_valid) got = 1'b1;
        else if (!g_reset) runs++;
      end
      chk("timeout_seen", 512'(got), 512'(1'b1));
      chk("timeout_run_cycles", 512'(runs), 512'(16));
      chk("timeout_result", 512'({resp_id, resp_err, c_out, r_out}),
          512'({1'b0, 1'b1, K0, R0}));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
